// File: rtl/note_scheduler.sv
// Song-run sequencer for the note lane: paces lane steps from the 1 ms tick, walks the
// 1-bit-per-step chart and drives one spawn bit per step through countdown, play and drain.
module note_scheduler #(
  parameter int STEP_MS         = 200,
  parameter int CHART_LEN       = 64,
  parameter int ADDR_W          = 6,
  parameter int COUNTDOWN_STEPS = 4,
  parameter int DRAIN_STEPS     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tick,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_chart_addr,
  input  logic              i_chart_data,
  output logic              o_step,
  output logic              o_spawn,
  output logic [ADDR_W-1:0] o_note_idx,
  output logic [2:0]        o_state,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_DRAIN     = 3'd3,
    S_PAUSE     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam int TCNT_W = $clog2(STEP_MS);
  localparam int SMAX   = (COUNTDOWN_STEPS > DRAIN_STEPS) ? COUNTDOWN_STEPS : DRAIN_STEPS;
  localparam int SCNT_W = (SMAX > 1) ? $clog2(SMAX) : 1;

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(STEP_MS - 1);
  localparam logic [SCNT_W-1:0] CD_LAST   = SCNT_W'(COUNTDOWN_STEPS - 1);
  localparam logic [SCNT_W-1:0] DR_LAST   = SCNT_W'(DRAIN_STEPS - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(CHART_LEN - 1);

  state_t              state_q, state_d;
  state_t              saved_q, saved_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                spawn_q, spawn_d;
  logic                step_q, step_d;
  logic                boundary;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      saved_q <= S_IDLE;
      tcnt_q  <= '0;
      scnt_q  <= '0;
      idx_q   <= '0;
      spawn_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
      idx_q   <= idx_d;
      spawn_q <= spawn_d;
      step_q  <= step_d;
    end
  end

  assign boundary = i_tick && (tcnt_q == TCNT_LAST);

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    tcnt_d  = tcnt_q;
    scnt_d  = scnt_q;
    idx_d   = idx_q;
    spawn_d = spawn_q;
    step_d  = 1'b0;

    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      spawn_d = 1'b0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            state_d = S_COUNTDOWN;
            idx_d   = '0;
            scnt_d  = '0;
            tcnt_d  = '0;
          end
        end
        S_COUNTDOWN, S_PLAY, S_DRAIN: begin
          if (i_pause) begin
            // Counters freeze, so a pause landing on a boundary tick defers that step.
            saved_d = state_q;
            state_d = S_PAUSE;
          end else if (i_tick) begin
            tcnt_d = boundary ? '0 : tcnt_q + 1'b1;
            if (boundary) begin
              step_d = 1'b1;
              case (state_q)
                S_COUNTDOWN: begin
                  spawn_d = 1'b0;
                  if (scnt_q == CD_LAST) begin
                    state_d = S_PLAY;
                    scnt_d  = '0;
                  end else begin
                    scnt_d = scnt_q + 1'b1;
                  end
                end
                S_PLAY: begin
                  // Address has been stable for a whole step, so the ROM latency is hidden.
                  spawn_d = i_chart_data;
                  if (idx_q == IDX_LAST) begin
                    state_d = S_DRAIN;
                    scnt_d  = '0;
                  end else begin
                    idx_d = idx_q + 1'b1;
                  end
                end
                default: begin
                  spawn_d = 1'b0;
                  if (scnt_q == DR_LAST) begin
                    state_d = S_DONE;
                    scnt_d  = '0;
                  end else begin
                    scnt_d = scnt_q + 1'b1;
                  end
                end
              endcase
            end
          end
        end
        S_PAUSE: begin
          if (!i_pause) state_d = saved_q;
        end
        S_DONE: begin
          state_d = S_IDLE;
          spawn_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          spawn_d = 1'b0;
          idx_d   = '0;
        end
      endcase
    end
  end

  assign o_chart_addr = idx_q;
  assign o_note_idx   = idx_q;
  assign o_step       = step_q;
  assign o_spawn      = spawn_q;
  assign o_state      = state_q;
  assign o_busy       = (state_q == S_COUNTDOWN) || (state_q == S_PLAY) ||
                        (state_q == S_DRAIN) || (state_q == S_PAUSE);
  assign o_done       = (state_q == S_DONE);

endmodule
